// File: rtl/seat_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seat_scan
//  Description : Reader end of the seat table. Walks every seat through a
//                request/valid read port, counts seats by state, releases
//                reservations whose hold time has run out by writing the seat
//                back to free, and publishes a registered occupancy summary
//                once per completed scan.
//
//  Ports
//    clk_scan                 : clock
//    rst_scan                 : synchronous active-high reset
//    start                    : one-cycle scan request (ignored while busy)
//    now_time / limit_time    : current time and reservation hold limit,
//                               both sampled when a scan starts
//    rd_req / rd_addr         : read request (held until rd_valid) and seat
//    rd_valid/rd_state/rd_time: read response (one-cycle valid pulse)
//    wr_en / wr_addr          : one-cycle clear strobe and seat
//    wr_state / wr_time       : always free / latched scan time
//    busy                     : scan in progress
//    scan_done                : one-cycle pulse, summary counters updated
//    scan_err                 : one-cycle pulse, scan aborted (read timeout)
//    free_cnt .. occ_cnt      : per-state counts of the last good scan
//    expired_cnt              : reservations cleared in the last good scan
//
//  Revision    : 1.0  initial release
// ============================================================================
module seat_scan #(
    parameter int NUM_SEATS  = 32,
    parameter int TW         = 11,
    parameter int RD_TIMEOUT = 15
) (
    input  logic          clk_scan,
    input  logic          rst_scan,
    input  logic          start,
    input  logic [TW-1:0] now_time,
    input  logic [TW-1:0] limit_time,
    output logic          rd_req,
    output logic [4:0]    rd_addr,
    input  logic          rd_valid,
    input  logic [1:0]    rd_state,
    input  logic [TW-1:0] rd_time,
    output logic          wr_en,
    output logic [4:0]    wr_addr,
    output logic [1:0]    wr_state,
    output logic [TW-1:0] wr_time,
    output logic          busy,
    output logic          scan_done,
    output logic          scan_err,
    output logic [5:0]    free_cnt,
    output logic [5:0]    resv_cnt,
    output logic [5:0]    away_cnt,
    output logic [5:0]    occ_cnt,
    output logic [5:0]    expired_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_REQ   = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_EVAL  = 3'd3;
    localparam logic [2:0] c_CLEAR = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    localparam logic [1:0] c_ST_FREE = 2'd0;
    localparam logic [1:0] c_ST_RESV = 2'd1;
    localparam logic [1:0] c_ST_AWAY = 2'd2;
    localparam logic [1:0] c_ST_OCC  = 2'd3;

    // Wait counter only has to reach RD_TIMEOUT-1: the cycle that would make
    // it RD_TIMEOUT is the abort cycle itself.
    localparam int               c_WCW       = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);
    localparam logic [c_WCW-1:0] c_WAIT_LAST = c_WCW'(RD_TIMEOUT - 1);
    localparam logic [4:0]       c_LAST_ADDR = 5'(NUM_SEATS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [4:0]       r_addr;
    logic [c_WCW-1:0] r_wait_cnt;
    logic [TW-1:0]    r_now;
    logic [TW-1:0]    r_limit;
    logic [1:0]       r_cap_state;
    logic [TW-1:0]    r_cap_time;

    // Working counters for the scan in progress
    logic [5:0]       r_free_w;
    logic [5:0]       r_resv_w;
    logic [5:0]       r_away_w;
    logic [5:0]       r_occ_w;
    logic [5:0]       r_exp_w;

    // Published summary and status
    logic             r_busy;
    logic             r_scan_done;
    logic             r_scan_err;
    logic [5:0]       r_free;
    logic [5:0]       r_resv;
    logic [5:0]       r_away;
    logic [5:0]       r_occ;
    logic [5:0]       r_exp;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [TW-1:0] w_elapsed;
    logic          w_expired;
    logic          w_last;
    logic          w_wait_expired;
    logic          w_advance;
    logic          w_step;

    // Unsigned TW-bit subtraction wraps naturally, so a stamp taken just
    // before the time counter rolled over still yields the true elapsed time.
    assign w_elapsed      = r_now - r_cap_time;
    assign w_expired      = (r_cap_state == c_ST_RESV) && (w_elapsed > r_limit);
    assign w_last         = (r_addr == c_LAST_ADDR);
    assign w_wait_expired = (r_wait_cnt == c_WAIT_LAST);

    // A seat is finished either in EVAL (nothing to clear) or in CLEAR.
    assign w_advance = ((r_state == c_EVAL) && !w_expired) || (r_state == c_CLEAR);
    assign w_step    = w_advance && !w_last;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state = c_REQ;
                end
            end
            c_REQ: begin
                w_next_state = c_WAIT;
            end
            c_WAIT: begin
                if (rd_valid) begin
                    w_next_state = c_EVAL;
                end else if (w_wait_expired) begin
                    w_next_state = c_IDLE;
                end
            end
            c_EVAL: begin
                if (w_expired) begin
                    w_next_state = c_CLEAR;
                end else if (w_last) begin
                    w_next_state = c_DONE;
                end else begin
                    w_next_state = c_REQ;
                end
            end
            c_CLEAR: begin
                if (w_last) begin
                    w_next_state = c_DONE;
                end else begin
                    w_next_state = c_REQ;
                end
            end
            c_DONE: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_scan) begin
        if (rst_scan) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Scan address, latched scan parameters, read capture, wait counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_scan) begin
        if (rst_scan) begin
            r_addr      <= 5'd0;
            r_now       <= '0;
            r_limit     <= '0;
            r_cap_state <= 2'd0;
            r_cap_time  <= '0;
            r_wait_cnt  <= '0;
        end else begin
            if ((r_state == c_IDLE) && start) begin
                r_addr  <= 5'd0;
                r_now   <= now_time;
                r_limit <= limit_time;
            end else if (w_step) begin
                r_addr <= r_addr + 5'd1;
            end

            if (r_state == c_REQ) begin
                r_wait_cnt <= '0;
            end else if ((r_state == c_WAIT) && !rd_valid && !w_wait_expired) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if ((r_state == c_WAIT) && rd_valid) begin
                r_cap_state <= rd_state;
                r_cap_time  <= rd_time;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Working counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_scan) begin
        if (rst_scan) begin
            r_free_w <= 6'd0;
            r_resv_w <= 6'd0;
            r_away_w <= 6'd0;
            r_occ_w  <= 6'd0;
            r_exp_w  <= 6'd0;
        end else if ((r_state == c_IDLE) && start) begin
            r_free_w <= 6'd0;
            r_resv_w <= 6'd0;
            r_away_w <= 6'd0;
            r_occ_w  <= 6'd0;
            r_exp_w  <= 6'd0;
        end else if (r_state == c_EVAL) begin
            if (w_expired) begin
                // Released seat ends the scan as free.
                r_exp_w  <= r_exp_w + 6'd1;
                r_free_w <= r_free_w + 6'd1;
            end else begin
                case (r_cap_state)
                    c_ST_FREE: r_free_w <= r_free_w + 6'd1;
                    c_ST_RESV: r_resv_w <= r_resv_w + 6'd1;
                    c_ST_AWAY: r_away_w <= r_away_w + 6'd1;
                    c_ST_OCC:  r_occ_w  <= r_occ_w  + 6'd1;
                    default:   r_free_w <= r_free_w;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status pulses and published summary
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_scan) begin
        if (rst_scan) begin
            r_busy      <= 1'b0;
            r_scan_done <= 1'b0;
            r_scan_err  <= 1'b0;
            r_free      <= 6'd0;
            r_resv      <= 6'd0;
            r_away      <= 6'd0;
            r_occ       <= 6'd0;
            r_exp       <= 6'd0;
        end else begin
            r_scan_done <= 1'b0;
            r_scan_err  <= 1'b0;

            if ((r_state == c_IDLE) && start) begin
                r_busy <= 1'b1;
            end

            // Read timeout: abandon the scan, keep the previous summary.
            if ((r_state == c_WAIT) && !rd_valid && w_wait_expired) begin
                r_busy     <= 1'b0;
                r_scan_err <= 1'b1;
            end

            if (r_state == c_DONE) begin
                r_busy      <= 1'b0;
                r_scan_done <= 1'b1;
                r_free      <= r_free_w;
                r_resv      <= r_resv_w;
                r_away      <= r_away_w;
                r_occ       <= r_occ_w;
                r_exp       <= r_exp_w;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Read request spans REQ and every WAIT cycle; writes only happen in
    // CLEAR, so the two ports are never active together.
    assign rd_req      = (r_state == c_REQ) || (r_state == c_WAIT);
    assign rd_addr     = r_addr;
    assign wr_en       = (r_state == c_CLEAR);
    assign wr_addr     = r_addr;
    assign wr_state    = c_ST_FREE;
    assign wr_time     = r_now;

    assign busy        = r_busy;
    assign scan_done   = r_scan_done;
    assign scan_err    = r_scan_err;
    assign free_cnt    = r_free;
    assign resv_cnt    = r_resv;
    assign away_cnt    = r_away;
    assign occ_cnt     = r_occ;
    assign expired_cnt = r_exp;

endmodule
`default_nettype wire

// File: doc/seat_scan.md
Name: seat_scan

Overview:
- Reader end of the seat table: walks all seats of the seat-state/time table through a request/valid read port.
- Counts seats by state (free, reserved, away, occupied) and releases expired reservations by issuing clear writes on the table write port.
- Publishes a registered occupancy summary for the kiosk display and control logic once per scan.

Parameters:
NUM_SEATS, 32, seats scanned (addresses 0..NUM_SEATS-1, max 32)
TW, 11, width of time stamps and limit
RD_TIMEOUT, 15, max cycles waiting for rd_valid before aborting scan

Ports:
clk_scan  input  1  clock
rst_scan  input  1  synchronous active-high reset
start  input  1  one-cycle scan request; ignored while busy
now_time  input  TW  current time; sampled at scan start
limit_time  input  TW  reservation hold limit; sampled at scan start
rd_req  output  1  read request, held until rd_valid
rd_addr  output  5  seat number being read
rd_valid  input  1  read data valid, one-cycle pulse
rd_state  input  2  seat state: 0 free, 1 reserved, 2 away, 3 occupied
rd_time  input  TW  stored time stamp for the seat
wr_en  output  1  one-cycle write strobe (clear)
wr_addr  output  5  seat to write
wr_state  output  2  always 0 (free) on a clear
wr_time  output  TW  sampled now_time
busy  output  1  scan in progress
scan_done  output  1  one-cycle pulse, summary updated
scan_err  output  1  one-cycle pulse, scan aborted on read timeout
free_cnt, resv_cnt, away_cnt, occ_cnt  output  6 each  per-state seat counts of last good scan
expired_cnt  output  6  reservations cleared in last good scan

Behaviour:
- Reset (rst_scan=1 at a clock edge): all outputs, internal counters and the FSM clear to 0/IDLE. Reset mid-scan abandons the scan with no write and no scan_done.
- FSM states: IDLE, REQ, WAIT, EVAL, CLEAR, DONE.
- IDLE: on start=1, latch now_time and limit_time, zero the working counters, set address=0, busy=1, go to REQ.
- REQ: assert rd_req with rd_addr=address, go to WAIT. rd_req stays high through WAIT.
- WAIT: on rd_valid=1, capture rd_state/rd_time, drop rd_req the next cycle, go to EVAL.
  - The wait counter increments each cycle without rd_valid.
  - On reaching RD_TIMEOUT: drop rd_req, pulse scan_err, leave the summary unchanged, go to IDLE.
- EVAL (one cycle):
  - elapsed = (now_latched - rd_time) mod 2^TW, an unsigned wrap-safe subtraction.
  - Expired when state==1 AND elapsed > limit_latched (strict; elapsed == limit is not expired).
  - Expired seat: expired_cnt_w++, free_cnt_w++, go to CLEAR.
  - Otherwise increment the counter for the captured state, then advance.
- CLEAR (one cycle): wr_en=1, wr_addr=address, wr_state=0, wr_time=now_latched, then advance.
- Advance:
  - If address==NUM_SEATS-1, go to DONE.
  - Else address++ and go to REQ.
- DONE (one cycle):
  - Copy the working counters to the output counters and pulse scan_done.
  - busy=0, go to IDLE.
  - Counts always sum to NUM_SEATS.
- Latency per seat: 3 cycles + read latency (+1 cycle if cleared).
- Full-scan minimum: 1 + NUM_SEATS*(3+L) + clears + 1 cycles.
- start asserted in any non-IDLE state is ignored (not queued). start in the same cycle as DONE is ignored; start in the next IDLE cycle is accepted.
- now_time/limit_time changes during a scan have no effect until the next scan.
- rd_valid outside WAIT is ignored.
- wr_en never coincides with rd_req.
- limit_time=0: every reserved seat with elapsed ≥ 1 expires.
- Output counters hold their values between scans and after scan_err.

Test Plan:
- Reset, then all-free table, start -> 32 reads at addresses 0..31, scan_done; free_cnt=32, others 0, no wr_en.
- Seat 5 reserved at time 100, now=200, limit=50 -> wr_en with wr_addr=5, wr_state=0, wr_time=200; expired_cnt=1, free_cnt=32, resv_cnt=0.
- Seat 7 reserved at time 2040, now=10, limit=30 (elapsed 18, wrap) -> no clear, resv_cnt=1. With now=60 (elapsed 68) -> cleared.
- Boundary: elapsed exactly 50 with limit 50 -> not cleared. Seat in state 3 and seat in state 2 with large elapsed -> never cleared, counted in occ_cnt/away_cnt.
- Responder withholds rd_valid at seat 12 for 15 cycles -> scan_err pulse, rd_req drops, counters keep the previous scan's values, busy=0.
- start pulses during a scan ignored. rst_scan asserted at seat 20 -> busy=0, all outputs 0 next cycle, no scan_done, no further wr_en.
